// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte-stream requesters, the arbiter and the
// shared uart_tx. The master side is the requester/transmitter environment,
// the slave side is the arbiter itself.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ack;
   logic [NUM_REQ-1:0]   grant;
   logic                 frame_abort;
   logic                 busy;
   logic [7:0]           tx_data;
   logic                 tx_data_ready;
   logic                 tx_done;

   modport master (
      output req_valid, req_data, req_last, tx_done,
      input  req_ack, grant, frame_abort, busy, tx_data, tx_data_ready
   );

   modport slave (
      input  req_valid, req_data, req_last, tx_done,
      output req_ack, grant, frame_abort, busy, tx_data, tx_data_ready
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte streams.
// Ownership changes only on frame boundaries (byte marked last) or when the
// owner stalls for STALL_TIMEOUT cycles in SEND.
module uart_tx_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int CLK_PER_BIT   = 16,
   parameter int STALL_TIMEOUT = 255
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   uart_tx_arbiter_if.slave bus
);
   localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int HOLD = 10 * CLK_PER_BIT;
   localparam int HW   = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam int SW   = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;

   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
   localparam logic [SW-1:0] STALL_MAX = SW'(STALL_TIMEOUT);
   localparam logic [PW-1:0] LAST_IDX  = PW'(NUM_REQ - 1);

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_SEND, S_WAIT} state_e;

   state_e             state_q, state_d;
   logic [HW-1:0]      hold_q, hold_d;
   logic [SW-1:0]      stall_q, stall_d;
   logic [PW-1:0]      rr_q, rr_d;
   logic [PW-1:0]      own_q, own_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic               ready_q, ready_d;
   logic               abort_q, abort_d;
   logic               last_q, last_d;
   logic               rel;

   logic [PW:0]        rr_idx;
   logic [PW-1:0]      rr_lo;
   logic [PW-1:0]      sel;
   logic               sel_vld;

   // First valid requester at or after rr_q, wrapping; the released owner
   // is therefore naturally the last candidate.
   always_comb begin
      sel     = '0;
      sel_vld = 1'b0;
      rr_idx  = '0;
      rr_lo   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         rr_idx = {1'b0, rr_q} + (PW+1)'(k);
         if (rr_idx >= (PW+1)'(NUM_REQ)) rr_idx = rr_idx - (PW+1)'(NUM_REQ);
         rr_lo = rr_idx[PW-1:0];
         if (!sel_vld && bus.req_valid[rr_lo]) begin
            sel_vld = 1'b1;
            sel     = rr_lo;
         end
      end
   end

   // Next-state and registered-output logic; tx_data_ready/req_ack/abort
   // default low so each is a single-cycle pulse.
   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      stall_d   = stall_q;
      rr_d      = rr_q;
      own_d     = own_q;
      grant_d   = grant_q;
      ack_d     = '0;
      ready_d   = 1'b0;
      abort_d   = 1'b0;
      tx_data_d = tx_data_q;
      last_d    = last_q;
      rel       = 1'b0;
      case (state_q)
         S_INIT: begin
            if (hold_q == HOLD_LAST) begin
               state_d = S_IDLE;
               hold_d  = '0;
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         S_IDLE: begin
            if (sel_vld) begin
               own_d        = sel;
               grant_d      = '0;
               grant_d[sel] = 1'b1;
               state_d      = S_SEND;
            end
         end
         S_SEND: begin
            if (bus.req_valid[own_q]) begin
               tx_data_d     = bus.req_data[{own_q, 3'b000} +: 8];
               ready_d       = 1'b1;
               ack_d[own_q]  = 1'b1;
               last_d        = bus.req_last[own_q];
               stall_d       = '0;
               state_d       = S_WAIT;
            end else begin
               if (stall_q != {SW{1'b1}}) stall_d = stall_q + SW'(1);
               if (STALL_TIMEOUT != 0 && (stall_q + SW'(1)) == STALL_MAX) begin
                  abort_d = 1'b1;
                  rel     = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (bus.tx_done) begin
               if (last_q) rel = 1'b1;
               else        state_d = S_SEND;
            end
         end
         default: state_d = S_INIT;
      endcase
      if (rel) begin
         grant_d = '0;
         stall_d = '0;
         state_d = S_IDLE;
         rr_d    = (own_q == LAST_IDX) ? '0 : own_q + PW'(1);
      end
   end

   // State and output registers with synchronous reset; a frame in flight
   // at reset is simply dropped.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q   <= S_INIT;
         hold_q    <= '0;
         stall_q   <= '0;
         rr_q      <= '0;
         own_q     <= '0;
         grant_q   <= '0;
         ack_q     <= '0;
         tx_data_q <= '0;
         ready_q   <= 1'b0;
         abort_q   <= 1'b0;
         last_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         stall_q   <= stall_d;
         rr_q      <= rr_d;
         own_q     <= own_d;
         grant_q   <= grant_d;
         ack_q     <= ack_d;
         tx_data_q <= tx_data_d;
         ready_q   <= ready_d;
         abort_q   <= abort_d;
         last_q    <= last_d;
      end
   end

   assign bus.req_ack       = ack_q;
   assign bus.grant         = grant_q;
   assign bus.frame_abort   = abort_q;
   assign bus.busy          = (state_q != S_IDLE);
   assign bus.tx_data       = tx_data_q;
   assign bus.tx_data_ready = ready_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: queue-based requesters, a behavioural transmitter
// that answers each start pulse with tx_done one frame time later, and a
// frame-level round-robin model predicting the byte order on the line.
module tb_uart_tx_arbiter;
   localparam int NR  = 4;
   localparam int CPB = 16;
   localparam int TO  = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(NR)) bus();

   uart_tx_arbiter #(.NUM_REQ(NR), .CLK_PER_BIT(CPB), .STALL_TIMEOUT(TO)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   int checks = 0, errors = 0;
   int cyc = 0, ucnt = 0, done_cyc = 0, abort_cyc = 0, abort_seen = 0, model_ptr = 0;
   bit gap_armed = 1'b0, pend_last = 1'b1;
   int ackcnt [NR];
   byte unsigned qd [NR][$];
   bit           ql [NR][$];
   int           exp_own[$], obs_own[$];
   byte unsigned exp_byte[$], obs_byte[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, want);
      end
   endtask

   function automatic int oh2i(input logic [NR-1:0] g);
      for (int i = 0; i < NR; i++) if (g[i]) return i;
      return -1;
   endfunction

   task automatic push(input int r, input byte unsigned b, input bit l);
      qd[r].push_back(b);
      ql[r].push_back(l);
   endtask

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         if (qd[i].size() > 0) begin
            bus.req_valid[i]       = 1'b1;
            bus.req_data[8*i +: 8] = qd[i][0];
            bus.req_last[i]        = ql[i][0];
         end else begin
            bus.req_valid[i]       = 1'b0;
            bus.req_data[8*i +: 8] = 8'h00;
            bus.req_last[i]        = 1'b0;
         end
      end
   endtask

   // One clock: sample after the edge, run the transmitter and requester
   // models, then drive the next inputs.
   task automatic tick();
      int o;
      bit ok;
      @(posedge clk);
      #1;
      cyc++;
      chk("grant_onehot0", 32'($onehot0(bus.grant)), 1);
      chk("ack_onehot0", 32'($onehot0(bus.req_ack)), 1);
      chk("ack_within_grant", 32'(bus.req_ack & ~bus.grant), 0);
      chk("ack_with_ready", 32'(|bus.req_ack), 32'(bus.tx_data_ready));
      if (bus.tx_done) begin
         bus.tx_done = 1'b0;
      end else if (ucnt > 0) begin
         ucnt--;
         if (ucnt == 0) begin
            bus.tx_done = 1'b1;
            done_cyc    = cyc;
            gap_armed   = !pend_last;
         end
      end
      if (bus.frame_abort === 1'b1) begin
         abort_seen++;
         abort_cyc = cyc;
         gap_armed = 1'b0;
      end
      if (bus.tx_data_ready === 1'b1) begin
         o  = oh2i(bus.grant);
         ok = (o >= 0) ? (qd[o].size() > 0) : 1'b0;
         chk("ready_has_owner", 32'(ok), 1);
         if (ok) begin
            chk("tx_byte", 32'(bus.tx_data), 32'(qd[o][0]));
            if (gap_armed) chk("done_to_ready", cyc - done_cyc, 2);
            obs_own.push_back(o);
            obs_byte.push_back(qd[o][0]);
            pend_last = ql[o][0];
            void'(qd[o].pop_front());
            void'(ql[o].pop_front());
            ackcnt[o]++;
         end
         ucnt      = 10 * CPB;
         gap_armed = 1'b0;
      end
      drive();
   endtask

   // Frame-level model: from the pointer, the first requester with a
   // pending frame sends that whole frame; the pointer moves past it.
   task automatic predict();
      byte unsigned cd [NR][$];
      bit           cl [NR][$];
      int p, idx, j;
      bit lst;
      for (int i = 0; i < NR; i++) begin
         cd[i] = qd[i];
         cl[i] = ql[i];
      end
      p = model_ptr;
      while (1) begin
         idx = -1;
         for (int k = 0; k < NR; k++) begin
            j = (p + k) % NR;
            if (idx < 0 && cd[j].size() > 0) idx = j;
         end
         if (idx < 0) break;
         lst = 1'b0;
         while (!lst && cd[idx].size() > 0) begin
            exp_own.push_back(idx);
            exp_byte.push_back(cd[idx].pop_front());
            lst = cl[idx].pop_front();
         end
         p = (idx + 1) % NR;
      end
      model_ptr = p;
   endtask

   task automatic compare(input string tag);
      int n;
      chk({tag, "_count"}, obs_own.size(), exp_own.size());
      n = (obs_own.size() < exp_own.size()) ? obs_own.size() : exp_own.size();
      for (int k = 0; k < n; k++) begin
         chk({tag, "_owner"}, obs_own[k], exp_own[k]);
         chk({tag, "_byte"}, 32'(obs_byte[k]), 32'(exp_byte[k]));
      end
      obs_own.delete(); obs_byte.delete(); exp_own.delete(); exp_byte.delete();
   endtask

   task automatic run_idle(input string tag);
      int n = 0;
      bit pend;
      do begin
         tick();
         n++;
         pend = 1'b0;
         for (int i = 0; i < NR; i++) if (qd[i].size() > 0) pend = 1'b1;
      end while ((pend || bus.busy || ucnt != 0 || bus.tx_done) && n < 20000);
      chk({tag, "_finished"}, 32'(n < 20000), 1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_tx_data"}, 32'(bus.tx_data), 0);
      chk({tag, "_ready"}, 32'(bus.tx_data_ready), 0);
      chk({tag, "_ack"}, 32'(bus.req_ack), 0);
      chk({tag, "_grant"}, 32'(bus.grant), 0);
      chk({tag, "_abort"}, 32'(bus.frame_abort), 0);
      chk({tag, "_busy"}, 32'(bus.busy), 1);
   endtask

   task automatic wait_init(input string tag);
      int n = 0, rdy = 0;
      do begin
         tick();
         n++;
         if (bus.tx_data_ready === 1'b1) rdy++;
      end while (bus.busy !== 1'b0 && n < 400);
      chk({tag, "_holdoff_len"}, n, 10 * CPB);
      chk({tag, "_no_ready"}, rdy, 0);
   endtask

   initial begin
      int n, a0, a3;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_last  = '0;
      bus.tx_done   = 1'b0;
      for (int i = 0; i < NR; i++) ackcnt[i] = 0;

      // Reset values and post-reset holdoff
      repeat (3) tick();
      chk_reset("reset");
      rst_n = 1'b1;
      wait_init("init");

      // Stray tx_done in IDLE
      bus.tx_done = 1'b1;
      tick();
      chk("stray_busy", 32'(bus.busy), 0);
      chk("stray_grant", 32'(bus.grant), 0);
      tick();
      chk("stray_ack", 32'(bus.req_ack), 0);
      chk("stray_ready", 32'(bus.tx_data_ready), 0);

      // Single requester, two-byte frame with grant/start latency
      push(0, 8'h5A, 1'b0);
      push(0, 8'hA5, 1'b1);
      predict();
      drive();
      tick();
      chk("lat_grant", 32'(bus.grant), 32'h1);
      chk("lat_no_ready", 32'(bus.tx_data_ready), 0);
      tick();
      chk("lat_ready", 32'(bus.tx_data_ready), 1);
      chk("lat_ack", 32'(bus.req_ack), 32'h1);
      chk("lat_data", 32'(bus.tx_data), 32'h5A);
      run_idle("single");
      compare("single");
      chk("single_acks", ackcnt[0], 2);
      chk("single_grant_end", 32'(bus.grant), 0);

      // Contention: requesters 1 and 2 raise valid together
      push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b1);
      push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b1);
      predict();
      drive();
      run_idle("contend");
      compare("contend");

      // Stall abort: requester 3 drops valid mid-frame, requester 0 waits
      a3 = ackcnt[3];
      push(3, 8'h77, 1'b0);
      drive();
      n = 0;
      while (bus.grant !== 4'b1000 && n < 10) begin tick(); n++; end
      chk("stall_grant3", 32'(bus.grant), 32'h8);
      push(0, 8'h33, 1'b1);
      drive();
      a0 = abort_seen;
      n = 0;
      while (abort_seen == a0 && n < 500) begin tick(); n++; end
      chk("stall_abort_seen", 32'(abort_seen - a0), 1);
      chk("stall_abort_latency", abort_cyc - done_cyc, 9);
      chk("stall_grant_cleared", 32'(bus.grant), 0);
      tick();
      chk("stall_regrant0", 32'(bus.grant), 32'h1);
      exp_own.push_back(3); exp_byte.push_back(8'h77);
      exp_own.push_back(0); exp_byte.push_back(8'h33);
      run_idle("stall");
      compare("stall");
      chk("stall_acks3", ackcnt[3] - a3, 1);
      model_ptr = 1;

      // Reset during WAIT
      push(1, 8'hAB, 1'b0);
      push(1, 8'hCD, 1'b1);
      drive();
      n = 0;
      while (bus.req_ack === '0 && n < 10) begin tick(); n++; end
      chk("rst_reached_wait", 32'(bus.req_ack), 32'h2);
      rst_n = 1'b0;
      tick();
      chk_reset("midreset");
      rst_n = 1'b1;
      for (int i = 0; i < NR; i++) begin qd[i].delete(); ql[i].delete(); end
      drive();
      obs_own.delete(); obs_byte.delete();
      model_ptr = 0;
      wait_init("reinit");
      gap_armed = 1'b0;
      pend_last = 1'b1;

      // Fairness: every requester sends two one-byte frames of its index
      for (int f = 0; f < 2; f++)
         for (int i = 0; i < NR; i++) push(i, 8'(i), 1'b1);
      predict();
      for (int k = 0; k < 2 * NR; k++) chk("fair_order", exp_own[k], k % NR);
      drive();
      run_idle("fair");
      compare("fair");

      // Random frame mixes
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < NR; i++) begin
            int nf = $urandom_range(0, 2);
            for (int f = 0; f < nf; f++) begin
               int len = $urandom_range(1, 3);
               for (int b = 0; b < len; b++) push(i, 8'($urandom), b == len - 1);
            end
         end
         predict();
         drive();
         run_idle("rand");
         compare("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
